// File: rtl/sales_total_reporter_if.sv
// Bundle between the sale-event logic, the sales-total reporter and the clear consumer.
// The reporter takes the slave view; the surrounding logic (or a bench) takes the master view.
interface sales_total_reporter_if #(
   parameter int TOTAL_W = 8,
   parameter int PRICE_W = 4,
   parameter int CNT_W   = 8
);
   logic               sale_valid;
   logic [PRICE_W-1:0] sale_amount;
   logic               sale_ready;
   logic               clear_req;
   logic [TOTAL_W-1:0] sales_total;
   logic [CNT_W-1:0]   sale_count;
   logic               overflow;
   logic               report_valid;
   logic               report_ack;
   logic               report_timeout;

   modport slave (
      input  sale_valid,
      input  sale_amount,
      input  clear_req,
      input  report_ack,
      output sale_ready,
      output sales_total,
      output sale_count,
      output overflow,
      output report_valid,
      output report_timeout
   );

   modport master (
      output sale_valid,
      output sale_amount,
      output clear_req,
      output report_ack,
      input  sale_ready,
      input  sales_total,
      input  sale_count,
      input  overflow,
      input  report_valid,
      input  report_timeout
   );
endinterface

// File: rtl/sales_total_reporter.sv
// Accumulates accepted sales into a saturating total and count, then reports a frozen
// snapshot on clear_req and zeroes it only once the consumer acknowledges.
//
// state  | meaning
// IDLE   | accepting sales; clear_req starts a report
// REPORT | snapshot held, report_valid high, waiting for report_ack or timeout
// CLEAR  | one cycle; totals are zeroed on the following edge
module sales_total_reporter #(
   parameter int TOTAL_W     = 8,
   parameter int PRICE_W     = 4,
   parameter int CNT_W       = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   sales_total_reporter_if.slave bus
);

   localparam int SUM_W = TOTAL_W + 1;
   localparam int TO_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REPORT = 2'd1,
      ST_CLEAR  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [TOTAL_W-1:0] total_q;
   logic [CNT_W-1:0]   count_q;
   logic               overflow_q;
   logic               timeout_q;
   logic [TO_W-1:0]    to_cnt;

   logic               sale_ready_c;
   logic               report_valid_c;
   logic               accept;
   logic               to_hit;
   logic [SUM_W-1:0]   sum;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   // Ack is checked before the timeout so an ack on the timeout edge still clears.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus.clear_req) state_nxt = ST_REPORT;
         end
         ST_REPORT: begin
            if (bus.report_ack)  state_nxt = ST_CLEAR;
            else if (to_hit)     state_nxt = ST_IDLE;
         end
         ST_CLEAR: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      sale_ready_c   = 1'b0;
      report_valid_c = 1'b0;
      case (state)
         ST_IDLE:   sale_ready_c   = 1'b1;
         ST_REPORT: report_valid_c = 1'b1;
         default: begin
            sale_ready_c   = 1'b0;
            report_valid_c = 1'b0;
         end
      endcase
   end

   assign accept = bus.sale_valid & sale_ready_c;
   assign to_hit = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
   assign sum    = {1'b0, total_q} + SUM_W'(bus.sale_amount);

   // ---------------------------------------------------------------- ack timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= (state == ST_REPORT) && !bus.report_ack && to_hit;
         if ((state == ST_REPORT) && (state_nxt == ST_REPORT)) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- accumulator
   // Sales can only be accepted in IDLE, so REPORT naturally holds the snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (state == ST_CLEAR) begin
         total_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         if (sum[TOTAL_W]) begin
            total_q    <= {TOTAL_W{1'b1}};
            overflow_q <= 1'b1;
         end else begin
            total_q    <= sum[TOTAL_W-1:0];
         end
         if (!(&count_q)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign bus.sale_ready     = sale_ready_c;
   assign bus.report_valid   = report_valid_c;
   assign bus.sales_total    = total_q;
   assign bus.sale_count     = count_q;
   assign bus.overflow       = overflow_q;
   assign bus.report_timeout = timeout_q;

endmodule

// File: tb/tb_sales_total_reporter.sv
// Self-checking bench for sales_total_reporter: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the reporter.
module tb_sales_total_reporter;

   localparam int TOTAL_W     = 8;
   localparam int PRICE_W     = 4;
   localparam int CNT_W       = 8;
   localparam int ACK_TIMEOUT = 16;
   localparam int TOTAL_MAX   = (1 << TOTAL_W) - 1;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   localparam int M_IDLE   = 0;
   localparam int M_REPORT = 1;
   localparam int M_CLEAR  = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sales_total_reporter_if #(.TOTAL_W(TOTAL_W), .PRICE_W(PRICE_W), .CNT_W(CNT_W)) bif ();

   sales_total_reporter #(
      .TOTAL_W(TOTAL_W), .PRICE_W(PRICE_W), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model
   int m_total, m_count, m_mode, m_wait;
   bit m_ovf, m_tp;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_total = 0; m_count = 0; m_ovf = 1'b0;
      m_mode  = M_IDLE; m_wait = 0; m_tp = 1'b0;
   endtask

   task automatic model_edge(input bit sv, input int amt, input bit cr, input bit ack);
      m_tp = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (sv) begin
               if (m_total + amt > TOTAL_MAX) m_ovf = 1'b1;
               m_total = (m_total + amt > TOTAL_MAX) ? TOTAL_MAX : m_total + amt;
               m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
            end
            if (cr) begin
               m_mode = M_REPORT;
               m_wait = 0;
            end
         end
         M_REPORT: begin
            if (ack) begin
               m_mode = M_CLEAR;
            end else begin
               m_wait++;
               if (m_wait == ACK_TIMEOUT) begin
                  m_mode = M_IDLE;
                  m_tp   = 1'b1;
               end
            end
         end
         default: begin
            m_total = 0; m_count = 0; m_ovf = 1'b0;
            m_mode  = M_IDLE;
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("sale_ready",     32'(bif.sale_ready),     32'(m_mode == M_IDLE));
      check_val("report_valid",   32'(bif.report_valid),   32'(m_mode == M_REPORT));
      check_val("sales_total",    32'(bif.sales_total),    32'(m_total));
      check_val("sale_count",     32'(bif.sale_count),     32'(m_count));
      check_val("overflow",       32'(bif.overflow),       32'(m_ovf));
      check_val("report_timeout", 32'(bif.report_timeout), 32'(m_tp));
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
   task automatic step(input bit sv, input int amt, input bit cr, input bit ack);
      bif.sale_valid  = sv;
      bif.sale_amount = PRICE_W'(amt);
      bif.clear_req   = cr;
      bif.report_ack  = ack;
      @(posedge clk);
      model_edge(sv, amt, cr, ack);
      #1;
      compare_all();
   endtask

   task automatic clear_cycle();
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bif.sale_valid  = 1'b0;
      bif.sale_amount = '0;
      bif.clear_req   = 1'b0;
      bif.report_ack  = 1'b0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // sales 3, 5, 7 back to back
      step(1, 3, 0, 0);
      check_val("total_after_3", 32'(bif.sales_total), 32'd3);
      step(1, 5, 0, 0);
      step(1, 7, 0, 0);
      check_val("total_15", 32'(bif.sales_total), 32'd15);
      check_val("count_3",  32'(bif.sale_count),  32'd3);
      clear_cycle();

      // saturation: reach 250, add 9, then 1
      for (int i = 0; i < 16; i++) step(1, 15, 0, 0);
      step(1, 10, 0, 0);
      check_val("total_250", 32'(bif.sales_total), 32'd250);
      step(1, 9, 0, 0);
      check_val("total_sat", 32'(bif.sales_total), 32'd255);
      check_val("ovf_set",   32'(bif.overflow),    32'd1);
      step(1, 1, 0, 0);
      check_val("total_hold", 32'(bif.sales_total), 32'd255);
      check_val("count_19",   32'(bif.sale_count),  32'd19);
      clear_cycle();
      check_val("ovf_cleared", 32'(bif.overflow), 32'd0);

      // sale and clear_req on the same edge, ack after 3 cycles
      step(1, 15, 0, 0);
      step(1, 5, 0, 0);
      step(1, 4, 1, 0);
      check_val("snap_valid", 32'(bif.report_valid), 32'd1);
      check_val("snap_total", 32'(bif.sales_total),  32'd24);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      check_val("clear_not_ready", 32'(bif.sale_ready), 32'd0);
      step(0, 0, 0, 0);
      check_val("cleared_total", 32'(bif.sales_total), 32'd0);
      check_val("cleared_ready", 32'(bif.sale_ready),  32'd1);

      // timeout keeps the total
      step(1, 15, 0, 0);
      step(1, 15, 0, 0);
      step(1, 12, 0, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < ACK_TIMEOUT; i++) step(0, 0, 0, 0);
      check_val("timeout_pulse", 32'(bif.report_timeout), 32'd1);
      check_val("timeout_total", 32'(bif.sales_total),    32'd42);
      step(0, 0, 0, 0);
      check_val("timeout_one_cycle", 32'(bif.report_timeout), 32'd0);
      clear_cycle();
      check_val("after_timeout_clear", 32'(bif.sales_total), 32'd0);

      // reset in the middle of a report
      step(1, 5, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check_val("pre_reset_valid", 32'(bif.report_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_valid", 32'(bif.report_valid), 32'd0);
      check_val("rst_total", 32'(bif.sales_total),  32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0);
      check_val("rst_ready", 32'(bif.sale_ready), 32'd1);

      // held sale across report/clear is accepted only after IDLE returns
      step(0, 0, 1, 0);
      step(1, 2, 0, 0);
      step(1, 2, 0, 0);
      step(1, 2, 0, 1);
      step(1, 2, 0, 0);
      step(1, 2, 0, 0);
      check_val("held_sale_total", 32'(bif.sales_total), 32'd2);
      step(0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 11) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sales_total_reporter.md
Name: sales_total_reporter

Overview:
- Producer side of the sales-total clear path: accumulates accepted sale amounts into a running total and count.
- On a clear request, freezes the total and presents it to the downstream clear/reset logic on `sales_total` with a valid/ack handshake.
- Zeroes the total only after the consumer acknowledges.
- Sits between the sale-event logic (upstream) and the total-clear consumer (downstream).

Parameters:
- TOTAL_W, 8, width of `sales_total` (saturating accumulator).
- PRICE_W, 4, width of one `sale_amount`.
- CNT_W, 8, width of `sale_count` (saturating).
- ACK_TIMEOUT, 16, cycles REPORT waits for `report_ack` before abandoning; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sale_valid  in  1  sale event present.
- sale_amount  in  PRICE_W  amount of the presented sale.
- sale_ready  out  1  block accepts a sale this cycle.
- clear_req  in  1  level request to report-and-clear, sampled each edge.
- sales_total  out  TOTAL_W  running total; frozen while reporting.
- sale_count  out  CNT_W  number of accepted sales since last clear.
- overflow  out  1  sticky; total saturated since last clear.
- report_valid  out  1  `sales_total` is a frozen snapshot awaiting ack.
- report_ack  in  1  consumer has taken the snapshot.
- report_timeout  out  1  one-cycle pulse when a report is abandoned.

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE, sales_total=0, sale_count=0, overflow=0, report_valid=0, report_timeout=0, timeout counter=0.
  - Applies mid-report too; no ack is needed after reset.
- sale_ready = 1 only in IDLE (combinational from state).
- Accept = sale_valid & sale_ready. On an accepting edge:
  - sales_total <= min(sales_total + sale_amount, 2^TOTAL_W−1); the sum is computed TOTAL_W+1 wide.
  - overflow <= 1 if the unclipped sum exceeds 2^TOTAL_W−1, else it holds.
  - sale_count <= min(sale_count+1, 2^CNT_W−1).
  - A zero sale_amount still counts.
  - Latency: the new total is visible one cycle after the accepting edge.
- FSM states: IDLE, REPORT, CLEAR.
- IDLE:
  - clear_req=1 at an edge → REPORT; report_valid=1 from the next cycle.
  - If a sale is accepted on that same edge, it is included in the snapshot (accumulate first, then freeze).
- REPORT:
  - sale_ready=0; sales_total, sale_count and overflow are held; report_valid=1.
  - Timeout counter increments each cycle.
  - report_ack=1 at an edge → CLEAR; report_valid=0 next cycle.
  - If ACK_TIMEOUT cycles elapse without ack → IDLE with values unchanged (not cleared), report_timeout=1 for one cycle, counter=0.
  - If ack arrives on the timeout edge, ack wins → CLEAR.
- CLEAR (exactly one cycle):
  - sale_ready=0, report_valid=0.
  - Next edge: sales_total=0, sale_count=0, overflow=0, counter=0, state → IDLE.
- clear_req is ignored in REPORT and CLEAR.
- If clear_req is still high on return to IDLE, a new report starts at the next edge; a zero total is reported normally.
- report_ack outside REPORT is ignored.
- sale_valid while sale_ready=0: the upstream holds the sale; the block does not record or drop it.

Test Plan:
- Reset, accept sales 3, 5, 7 on consecutive cycles → sales_total=15, sale_count=3, overflow=0; each update visible one cycle after its accept edge.
- From total=250, accept amount 9 → sales_total=255, overflow=1; a further sale of 1 → total stays 255, sale_count increments.
- Total=20, sale_valid with amount 4 and clear_req on the same edge → report_valid=1 next cycle with sales_total=24. Ack after 3 cycles → one CLEAR cycle with sale_ready=0, then total=0, count=0, sale_ready=1.
- Report total=42, no ack for ACK_TIMEOUT=16 cycles → report_timeout pulses once, IDLE resumes with total=42 retained; the next clear_req+ack clears it.
- Drive rst_n low mid-REPORT with report_valid=1 → immediately report_valid=0, sales_total=0, sale_ready=1 after release.
- Hold sale_valid=1 with amount 2 through a REPORT/CLEAR sequence → no accepts while sale_ready=0; the first accept after IDLE gives total=2.
